matrix_mult_stream: RTL and testbench
=====================================

Name: matrix_mult_stream

Overview:
Parametrised N x N matrix multiplier computing C = A x B.
- A and B elements are loaded as row-major pairs through a valid/ready input stream.
- C is computed with a single sequential multiply-accumulate unit.
- C is drained row-major through a valid/ready output stream with an end-of-matrix marker.
- It replaces the fixed 4x4, 16-bit serial multiplier as the compute core of the accelerator datapath.

Parameters:
- N, 4, matrix dimension (N >= 2).
- DW, 16, element width of A and B.
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands.
- AW (localparam), 2*DW + clog2(N), result/accumulator width; cannot overflow.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  an A/B element pair is presented.
- in_ready  output  1  block accepts a pair this cycle.
- in_a  input  DW  element A[r][c], row-major order.
- in_b  input  DW  element B[r][c], row-major order, same index as in_a.
- out_valid  output  1  out_c holds a valid C element.
- out_ready  input  1  downstream accepts out_c.
- out_c  output  AW  element C[i][j], row-major order.
- out_last  output  1  high with out_valid on C[N-1][N-1].
- busy  output  1  high whenever state != LOAD.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_c=0, out_last=0, busy=0, state=LOAD, all counters=0. A/B/C storage need not be cleared.
- State machine: LOAD -> COMPUTE -> DRAIN -> LOAD.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid && in_ready writes in_a into A[idx] and in_b into B[idx], then idx++.
  - On the N*N-th accept, go to COMPUTE and reset idx.
  - in_valid with in_ready=0 is ignored; the data is not captured.
- COMPUTE:
  - in_ready=0. Exactly N^3 cycles; one MAC per cycle, loops i (outer), j, k (inner).
  - At k=0 the accumulator loads the product directly (clear-and-accumulate). Otherwise acc += A[i][k]*B[k][j].
  - At k=N-1 the final sum is written to C[i][j].
  - After the last (i,j,k) cycle, go to DRAIN.
- Latency: if the last input is accepted at cycle t, out_valid first rises at cycle t+N^3+1.
- DRAIN:
  - out_valid=1, out_c=C[oidx], out_last=(oidx==N*N-1).
  - Output advances only on out_valid && out_ready; out_c and out_last hold stable while out_ready=0.
  - After the accept with out_last=1, go to LOAD. in_ready=1 the following cycle, with no dead cycle beyond that.
- Outputs outside DRAIN: out_c=0 and out_last=0 whenever out_valid=0.
- Arithmetic:
  - Products are full 2*DW width, sign- or zero-extended to AW per SIGNED. Accumulation is in AW bits, so no saturation or wrap is possible.
  - SIGNED=1: in_a/in_b are two's complement and out_c is a two's-complement AW-bit value.
- Reset mid-operation: rst asserted in any state asynchronously forces the reset values. Partial loads and computations are discarded. No stale C value may appear on out_c afterwards.
- out_ready is ignored outside DRAIN. in_valid is ignored outside LOAD.

Decomposition:
- Package matrix_mult_pkg holds:
  - the state enum (LOAD, COMPUTE, DRAIN);
  - a clog2 constant function;
  - an accumulator-width helper function acc_w(DW, N).
- Sub-module mm_mac (parameters DW, AW, SIGNED):
  - ports: clk, rst, en, clr, a, b, acc.
  - registered clear-or-accumulate with sign/zero extension.
- Top level holds the FSM, index counters, A/B/C storage and handshake logic.

Test Plan:
- Identity: N=4, A=I, B[r][c]=4r+c+1, out_ready=1 -> C equals B; 16 outputs; out_last only on the 16th (value 16).
- Latency/throughput: N=4, in_valid held high -> in_ready low exactly 1+64+16 cycles after load completes; first out_valid 65 cycles after the last accept.
- Max unsigned: N=4, DW=16, all elements 16'hFFFF -> every C = 34'h3_FFF8_0004, no overflow (AW=34).
- Signed: SIGNED=1, N=2, A=[[-1,2],[3,-4]], B=[[5,-6],[-7,8]] -> C=[[-19,22],[43,-50]].
- Backpressure: out_ready toggled 1,0,0,1 pattern -> no element lost or duplicated; out_c and out_last stable while stalled.
- Reset mid-COMPUTE: rst pulsed at MAC cycle 30 -> out_valid=0, busy=0, in_ready=1 immediately. A fresh load of A=I, B=2I then yields C=2I exactly.

Source files
------------

// File: rtl/matrix_mult_pkg.sv
// Shared types and width helpers for the streaming matrix multiplier.
// Holds the FSM state enum, a constant clog2 and the accumulator width rule.
package matrix_mult_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    // Smallest r with 2**r >= v; usable in parameter expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A full-width product plus clog2(n) guard bits holds a sum of n products
    // without overflow, signed or unsigned.
    function automatic int acc_w(input int dw, input int n);
        return 2 * dw + clog2(n);
    endfunction

endpackage

// File: rtl/matrix_mult_mac.sv
// mm_mac: registered multiply-accumulate with clear-and-load on clr.
// Ports: clk, rst (async high), en, clr, a/b operands (DW), acc result (AW).
module mm_mac #(
    parameter int DW     = 16,
    parameter int AW     = 34,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] acc
);

    logic          sa;
    logic          sb;
    logic [2*DW-1:0] prod;
    logic [AW-1:0] ext;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] acc_q;

    // Operands are pre-extended to 2*DW so one unsigned multiplier serves both
    // modes: the low 2*DW bits of the product are exact in either case.
    always_comb begin
        sa   = (SIGNED != 0) && a[DW-1];
        sb   = (SIGNED != 0) && b[DW-1];
        prod = {{DW{sa}}, a} * {{DW{sb}}, b};
        ext  = {{(AW-2*DW){(SIGNED != 0) && prod[2*DW-1]}}, prod};
    end

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = clr ? ext : acc_q + ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matrix_mult_stream.sv
// matrix_mult_stream: N x N matrix multiply C = A x B over valid/ready streams.
// Ports: clk, rst, in_valid/in_ready/in_a/in_b (load), out_valid/out_ready/
// out_c/out_last (drain), busy (not in LOAD).
module matrix_mult_stream
    import matrix_mult_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 16,
    parameter int SIGNED = 0,
    localparam int AW    = acc_w(DW, N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_c,
    output logic          out_last,
    output logic          busy
);

    localparam int NN = N * N;
    localparam int IW = clog2(NN);
    localparam int CW = clog2(N);

    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
    localparam logic [CW-1:0] LAST_N   = CW'(N - 1);

    state_e state_q, state_d;

    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;
    logic [CW-1:0] k_q, k_d;
    logic          wr_q, wr_d;
    logic [IW-1:0] widx_q, widx_d;

    logic          ab_we;
    logic          mac_en;
    logic          mac_clr;
    logic [IW-1:0] a_rd_idx;
    logic [IW-1:0] b_rd_idx;
    logic [IW-1:0] c_wr_idx;
    logic [AW-1:0] acc;

    logic [DW-1:0] a_mem_q [NN];
    logic [DW-1:0] b_mem_q [NN];
    logic [AW-1:0] c_mem_q [NN];

    always_comb begin
        a_rd_idx = IW'(i_q) * IW'(N) + IW'(k_q);
        b_rd_idx = IW'(k_q) * IW'(N) + IW'(j_q);
        c_wr_idx = IW'(i_q) * IW'(N) + IW'(j_q);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        wr_d      = 1'b0;
        widx_d    = widx_q;
        ab_we     = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ab_we = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = COMPUTE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            COMPUTE: begin
                mac_en  = 1'b1;
                mac_clr = (k_q == '0);
                if (k_q == LAST_N) begin
                    // The sum finishes in the MAC register this edge, so the
                    // C write is issued one cycle later from wr_q/widx_q.
                    k_d    = '0;
                    wr_d   = 1'b1;
                    widx_d = c_wr_idx;
                    if (j_q == LAST_N) begin
                        j_d = '0;
                        if (i_q == LAST_N) begin
                            i_d     = '0;
                            state_d = DRAIN;
                        end else begin
                            i_d = i_q + CW'(1);
                        end
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (idx_q == LAST_IDX);
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // The delayed last C write lands in the first DRAIN cycle; the drain
    // index cannot reach that entry before at least three more cycles.
    always_comb begin
        out_c = '0;
        if (state_q == DRAIN) begin
            out_c = c_mem_q[idx_q];
        end
    end

    assign busy = (state_q != LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            wr_q    <= 1'b0;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            wr_q    <= wr_d;
            widx_q  <= widx_d;
        end
    end

    // Storage is never read before being rewritten after a load, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (ab_we) begin
            a_mem_q[idx_q] <= in_a;
            b_mem_q[idx_q] <= in_b;
        end
        if (wr_q) begin
            c_mem_q[widx_q] <= acc;
        end
    end

    mm_mac #(
        .DW     (DW),
        .AW     (AW),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .en  (mac_en),
        .clr (mac_clr),
        .a   (a_mem_q[a_rd_idx]),
        .b   (b_mem_q[b_rd_idx]),
        .acc (acc)
    );

endmodule

// File: tb/tb_matrix_mult_stream.sv
// Scoreboard bench for matrix_mult_stream: unsigned 4x4 and signed 2x2 cores.
// Stimulus pushes expected C elements; negedge monitors pop and compare.
module tb_matrix_mult_stream;

    localparam int AWM = 34;
    localparam int AWS = 33;

    typedef struct packed {
        logic [63:0] c;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_a;
    logic [15:0]     in_b;
    logic            out_valid;
    logic            out_ready;
    logic [AWM-1:0]  out_c;
    logic            out_last;
    logic            busy;

    logic            s_in_valid;
    logic            s_in_ready;
    logic [15:0]     s_in_a;
    logic [15:0]     s_in_b;
    logic            s_out_valid;
    logic            s_out_ready;
    logic [AWS-1:0]  s_out_c;
    logic            s_out_last;
    logic            s_busy;

    exp_t q_m[$];
    exp_t q_s[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int t_acc      = 0;
    bit bp_en      = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    matrix_mult_stream #(
        .N      (4),
        .DW     (16),
        .SIGNED (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_last  (out_last),
        .busy      (busy)
    );

    matrix_mult_stream #(
        .N      (2),
        .DW     (16),
        .SIGNED (1)
    ) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_a      (s_in_a),
        .in_b      (s_in_b),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_c     (s_out_c),
        .out_last  (s_out_last),
        .busy      (s_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor for the unsigned core.
    always @(negedge clk) begin
        if (!rst) begin
            compared++;
            if (out_valid) begin
                if (q_m.size() == 0) begin
                    mismatched++;
                    $display("FAIL extra_out: got %0h want none", out_c);
                end else if (out_c != q_m[0].c[AWM-1:0] ||
                             out_last != q_m[0].last) begin
                    mismatched++;
                    $display("FAIL out_c: got %0h/%0b want %0h/%0b",
                             out_c, out_last, q_m[0].c, q_m[0].last);
                    if (out_ready) void'(q_m.pop_front());
                end else if (out_ready) begin
                    void'(q_m.pop_front());
                end
            end else if (out_c != '0 || out_last) begin
                mismatched++;
                $display("FAIL idle_out: got %0h/%0b want 0/0",
                         out_c, out_last);
            end
        end
    end

    // Monitor for the signed core.
    always @(negedge clk) begin
        if (!rst && s_out_valid) begin
            compared++;
            if (q_s.size() == 0) begin
                mismatched++;
                $display("FAIL s_extra: got %0h want none", s_out_c);
            end else begin
                if (s_out_c != q_s[0].c[AWS-1:0] ||
                    s_out_last != q_s[0].last) begin
                    mismatched++;
                    $display("FAIL s_out_c: got %0h/%0b want %0h/%0b",
                             s_out_c, s_out_last,
                             q_s[0].c[AWS-1:0], q_s[0].last);
                end
                if (s_out_ready) void'(q_s.pop_front());
            end
        end
    end

    // out_ready pattern 1,0,0,1 while backpressure is enabled.
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                out_ready = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic push_m(input logic [63:0] c, input logic last);
        q_m.push_back({c, last});
    endtask

    task automatic push_s(input logic [63:0] c, input logic last);
        q_s.push_back({c, last});
    endtask

    // Feed 16 pairs; each accept is the edge after a negedge with in_ready.
    task automatic load_m(input logic [15:0] a[16],
                          input logic [15:0] b[16], input bit hold);
        int n;
        for (int e = 0; e < 16; e++) begin
            in_a = a[e];
            in_b = b[e];
            in_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 1000) begin
                compared++;
                mismatched++;
                $display("FAIL load_m: got stall want in_ready");
            end
            t_acc = cyc;
            @(posedge clk);
            #1;
        end
        if (hold) begin
            in_a = 16'hDEAD;
            in_b = 16'hBEEF;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic load_s(input logic [15:0] a[4], input logic [15:0] b[4]);
        int n;
        for (int e = 0; e < 4; e++) begin
            s_in_a = a[e];
            s_in_b = b[e];
            s_in_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!s_in_ready && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 1000) begin
                compared++;
                mismatched++;
                $display("FAIL load_s: got stall want in_ready");
            end
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
    endtask

    task automatic wait_m(input string nm);
        int n;
        n = 0;
        while ((q_m.size() != 0 || !in_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 3000) begin
            mismatched++;
            $display("FAIL %s: got %0d left want 0", nm, q_m.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_s(input string nm);
        int n;
        n = 0;
        while ((q_s.size() != 0 || !s_in_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 3000) begin
            mismatched++;
            $display("FAIL %s: got %0d left want 0", nm, q_s.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] a[16];
        logic [15:0] b[16];
        logic [15:0] sa[4];
        logic [15:0] sb[4];
        longint      acc;
        int          t_ov;
        int          t_ir;

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        s_in_valid = 1'b0;
        s_in_a = '0;
        s_in_b = '0;
        s_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_c", 64'(out_c), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Identity A, B[r][c] = 4r+c+1, in_valid held through compute/drain.
        for (int e = 0; e < 16; e++) begin
            a[e] = (e / 4 == e % 4) ? 16'd1 : 16'd0;
            b[e] = 16'(e + 1);
            push_m(64'(e + 1), e == 15);
        end
        load_m(a, b, 1'b1);
        chk("busy_compute", 64'(busy), 64'd1);
        t_ov = -1;
        t_ir = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (out_valid && t_ov < 0) t_ov = cyc;
            if (in_ready) begin
                t_ir = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        chk("latency_out_valid", 64'(t_ov - t_acc), 64'd65);
        chk("in_ready_return", 64'(t_ir - t_acc), 64'd81);
        wait_m("identity_drain");

        // Every element at the unsigned maximum.
        for (int e = 0; e < 16; e++) begin
            a[e] = 16'hFFFF;
            b[e] = 16'hFFFF;
            push_m(64'h3_FFF8_0004, e == 15);
        end
        load_m(a, b, 1'b0);
        wait_m("max_drain");

        // General matrix under 1,0,0,1 backpressure.
        for (int e = 0; e < 16; e++) begin
            a[e] = 16'(e + 1);
            b[e] = 16'(16 - e);
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) begin
                    acc += longint'(a[i*4+k]) * longint'(b[k*4+j]);
                end
                push_m(64'(acc), (i == 3) && (j == 3));
            end
        end
        bp_en = 1'b1;
        load_m(a, b, 1'b0);
        wait_m("backpressure_drain");
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset in MAC cycle 30, then a fresh A=I, B=2I load.
        load_m(a, b, 1'b0);
        while (cyc < t_acc + 30) @(negedge clk);
        chk("busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int e = 0; e < 16; e++) begin
            a[e] = (e / 4 == e % 4) ? 16'd1 : 16'd0;
            b[e] = (e / 4 == e % 4) ? 16'd2 : 16'd0;
            push_m(64'(b[e]), e == 15);
        end
        load_m(a, b, 1'b0);
        wait_m("after_rst_drain");

        // Signed 2x2: [[-1,2],[3,-4]] x [[5,-6],[-7,8]].
        sa = '{16'hFFFF, 16'd2, 16'd3, 16'hFFFC};
        sb = '{16'd5, 16'hFFFA, 16'hFFF9, 16'd8};
        push_s(64'h1_FFFF_FFED, 1'b0);
        push_s(64'h0_0000_0016, 1'b0);
        push_s(64'h0_0000_002B, 1'b0);
        push_s(64'h1_FFFF_FFCE, 1'b1);
        load_s(sa, sb);
        wait_s("signed_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
